// File: rtl/pipe_irq_ctrl_if.sv
// Pipeline sequencer interface.
// Groups the stage stall requests, the EX redirect/trap inputs and the
// sequencer outputs (stall vector, flushes, redirect address, trap state).
//   master : core side, drives requests and consumes the sequencer outputs
//   slave  : pipe_irq_ctrl side
interface pipe_irq_ctrl_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int CAUSE_WIDTH = 4
);
    logic                   stall_req_if_in;
    logic                   stall_req_id_in;
    logic                   stall_req_ex_in;
    logic                   stall_req_mem_in;
    logic                   jump_req_in;
    logic [ADDR_WIDTH-1:0]  jump_target_in;
    logic [ADDR_WIDTH-1:0]  ex_pc_in;
    logic                   irq_in;
    logic [CAUSE_WIDTH-1:0] irq_cause_in;
    logic                   irq_enable_in;
    logic [ADDR_WIDTH-1:0]  trap_vector_in;
    logic                   mret_in;

    logic [5:0]             stall_out;
    logic                   jump_flush_out;
    logic                   interrupt_flush_out;
    logic [ADDR_WIDTH-1:0]  flush_address_out;
    logic                   irq_ack_out;
    logic [ADDR_WIDTH-1:0]  epc_out;
    logic [CAUSE_WIDTH-1:0] cause_out;
    logic                   in_isr_out;

    modport master (
        output stall_req_if_in, stall_req_id_in, stall_req_ex_in, stall_req_mem_in,
               jump_req_in, jump_target_in, ex_pc_in, irq_in, irq_cause_in,
               irq_enable_in, trap_vector_in, mret_in,
        input  stall_out, jump_flush_out, interrupt_flush_out, flush_address_out,
               irq_ack_out, epc_out, cause_out, in_isr_out
    );

    modport slave (
        input  stall_req_if_in, stall_req_id_in, stall_req_ex_in, stall_req_mem_in,
               jump_req_in, jump_target_in, ex_pc_in, irq_in, irq_cause_in,
               irq_enable_in, trap_vector_in, mret_in,
        output stall_out, jump_flush_out, interrupt_flush_out, flush_address_out,
               irq_ack_out, epc_out, cause_out, in_isr_out
    );
endinterface

// File: rtl/pipe_irq_ctrl.sv
// Central pipeline sequencer for the 5-stage core.
// Merges stage stall requests into the 6-bit stall vector
// ([0]=PC .. [5]=WB, 1 = stop), arbitrates EX branch/jump redirects
// against interrupt entry/return, and holds EPC/cause for the trap path.
// Ports:
//   clk_in     : core clock, rising edge
//   reset_n_in : asynchronous active-low reset
//   bus        : pipe_irq_ctrl_if slave modport (requests in, controls out)
module pipe_irq_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int CAUSE_WIDTH = 4
) (
    input  logic            clk_in,
    input  logic            reset_n_in,
    pipe_irq_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_ENTER,
        ST_ISR,
        ST_RETURN
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  epc_q, epc_d;
    logic [CAUSE_WIDTH-1:0] cause_q, cause_d;
    logic                   in_isr_q, in_isr_d;

    logic [5:0]             stall_merge;
    logic [5:0]             stall_c;
    logic                   jump_flush_c;
    logic                   int_flush_c;
    logic [ADDR_WIDTH-1:0]  flush_addr_c;
    logic                   irq_ack_c;
    logic                   any_stall_req;
    logic                   irq_pending;

    assign any_stall_req = bus.stall_req_if_in | bus.stall_req_id_in |
                           bus.stall_req_ex_in | bus.stall_req_mem_in;
    assign irq_pending   = bus.irq_in & bus.irq_enable_in;

    // Deepest requesting stage stops itself and everything upstream.
    always_comb begin
        stall_merge = '0;
        if (bus.stall_req_mem_in)      stall_merge = 6'b011111;
        else if (bus.stall_req_ex_in)  stall_merge = 6'b001111;
        else if (bus.stall_req_id_in)  stall_merge = 6'b000111;
        else if (bus.stall_req_if_in)  stall_merge = 6'b000011;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q  <= ST_RUN;
            epc_q    <= '0;
            cause_q  <= '0;
            in_isr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            in_isr_q <= in_isr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        epc_d        = epc_q;
        cause_d      = cause_q;
        in_isr_d     = in_isr_q;
        stall_c      = stall_merge;
        jump_flush_c = 1'b0;
        int_flush_c  = 1'b0;
        flush_addr_c = '0;
        irq_ack_c    = 1'b0;

        case (state_q)
            ST_RUN: begin
                // A same-cycle jump is honoured; the drain begins next cycle.
                if (bus.jump_req_in) begin
                    jump_flush_c = 1'b1;
                    flush_addr_c = bus.jump_target_in;
                end
                if (irq_pending) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                stall_c[0] = 1'b1;
                if (!irq_pending) begin
                    state_d = ST_RUN;
                end else if (!any_stall_req) begin
                    // A jump resolving on the release cycle is where the
                    // interrupted program must resume.
                    epc_d   = bus.jump_req_in ? bus.jump_target_in : bus.ex_pc_in;
                    cause_d = bus.irq_cause_in;
                    state_d = ST_ENTER;
                end
            end
            ST_ENTER: begin
                stall_c      = '0;
                int_flush_c  = 1'b1;
                flush_addr_c = bus.trap_vector_in;
                irq_ack_c    = 1'b1;
                in_isr_d     = 1'b1;
                state_d      = ST_ISR;
            end
            ST_ISR: begin
                if (bus.mret_in) begin
                    state_d = ST_RETURN;
                end else if (bus.jump_req_in) begin
                    jump_flush_c = 1'b1;
                    flush_addr_c = bus.jump_target_in;
                end
            end
            ST_RETURN: begin
                int_flush_c  = 1'b1;
                flush_addr_c = epc_q;
                in_isr_d     = 1'b0;
                state_d      = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign bus.stall_out           = stall_c;
    assign bus.jump_flush_out      = jump_flush_c;
    assign bus.interrupt_flush_out = int_flush_c;
    assign bus.flush_address_out   = flush_addr_c;
    assign bus.irq_ack_out         = irq_ack_c;
    assign bus.epc_out             = epc_q;
    assign bus.cause_out           = cause_q;
    assign bus.in_isr_out          = in_isr_q;

endmodule
